seq_multdiv_responder: RTL

Iterative signed 32-bit multiply/divide coprocessor. It is the responder end of the pipeline's mult/div handshake. The processor's DX stage issues a single-cycle ctrl_MULT or ctrl_DIV pulse with operands. This block computes serially and returns the result with a one-cycle data_resultRDY pulse, which the pipeline uses to release its stall and write back to rd.

---
 rtl/seq_multdiv_responder_pkg.sv | 13 +
 rtl/seq_multdiv_responder_div_step.sv | 21 ++
 rtl/seq_multdiv_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_multdiv_responder_pkg.sv
// seq_multdiv_responder_pkg: shared constants for the iterative mult/div responder
// State encoding, default width, ALU-op codes that the decode/stall logic
// uses to generate starts, and the most negative signed value.
package seq_multdiv_responder_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};
endpackage

// File: rtl/seq_multdiv_responder_div_step.sv
// div_restore_step: one combinational restoring-division iteration on magnitudes
// Ports: rem_i/quo_i current partial remainder and dividend/quotient shift register,
//        dvs_i divisor magnitude, rem_o/quo_o the pair after one shift-subtract.
module div_restore_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);
    logic [W:0] shifted;
    logic [W:0] diff;
    logic       ge;
    assign shifted = {rem_i, quo_i[W-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign ge      = shifted >= {1'b0, dvs_i};
    assign rem_o   = ge ? diff[W-1:0] : shifted[W-1:0];
    assign quo_o   = {quo_i[W-2:0], ge};
endmodule

// File: rtl/seq_multdiv_responder.sv
// seq_multdiv_responder: iterative signed multiply/divide responder, one bit per clock
// Ports: clock/reset (async, active-high); data_operandA/B operands latched on start;
//        ctrl_MULT/ctrl_DIV start pulses (MULT wins); data_result, data_exception
//        registered at completion; data_resultRDY one-cycle done pulse; data_busy in flight.
module seq_multdiv_responder
    import seq_multdiv_responder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic               start, last;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_n, quo_n, quo_s;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] mul_acc, prod;
    logic [WIDTH:0]     prod_top;
    assign start = (state_q == ST_IDLE || state_q == ST_DONE) && (ctrl_MULT || ctrl_DIV);
    assign last  = cnt_q == CW'(WIDTH - 1);
    // Both datapaths work on magnitudes; the sign is restored at completion.
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    // Shift-add: acc low half holds the remaining multiplier bits, high half the sum.
    assign hi_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_acc = {hi_sum, acc_q[WIDTH-1:1]};
    assign prod    = neg_q ? -mul_acc : mul_acc;
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    div_restore_step #(.W(WIDTH)) u_step (
        .rem_i(acc_q[2*WIDTH-1:WIDTH]),
        .quo_i(acc_q[WIDTH-1:0]),
        .dvs_i(b_q),
        .rem_o(rem_n),
        .quo_o(quo_n)
    );
    assign quo_s = neg_q ? -quo_n : quo_n;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        neg_d   = neg_q;
        res_d   = res_q;
        exc_d   = exc_q;
        if (start) begin
            state_d = ctrl_MULT ? ST_MUL : ST_DIV;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else if (state_q == ST_MUL) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = mul_acc;
            if (last) begin
                state_d = ST_DONE;
                res_d   = prod[WIDTH-1:0];
                exc_d   = !((&prod_top) || !(|prod_top));
            end
        end else if (state_q == ST_DIV) begin
            cnt_d = cnt_q + CW'(1);
            acc_d = {rem_n, quo_n};
            if (last) begin
                state_d = ST_DONE;
                res_d   = (b_q == '0) ? '0 : quo_s;
                // A positive quotient with the top bit set only arises from INT_MIN / -1.
                exc_d   = (b_q == '0) || (!neg_q && quo_n[WIDTH-1]);
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = state_q == ST_DONE;
    assign data_busy      = state_q == ST_MUL || state_q == ST_DIV;
endmodule
